mac_dot_product: RTL and testbench

- Multiply-accumulate stage directly downstream of the two 8-bit operand registers in the matrix-multiplication datapath.
- Accepts LEN operand pairs (one row element and one column element per pair) over a valid/ready handshake.
- Multiplies each pair, accumulates the products and presents one dot-product result, i.e. one element of the product matrix.
- The result is held on a valid/ready output handshake until the result writer consumes it.

---
 rtl/mac_dot_product.sv | 129 ++++++++++++
 tb/tb_mac_dot_product.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_product.sv
// Dot-product MAC stage: LEN operand pairs in, one ACC_W-bit sum out.
// Define MAC_SATURATE_EN for a saturating accumulator with sticky ovf.
module mac_dot_product #(
  parameter int DATA_W = 8,
  parameter int LEN    = 3,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_e                state_q;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_d;
  logic [ACC_W-1:0]      result_q;
  logic [7:0]            cnt_q;
  logic [2*DATA_W-1:0]   prod_q;
  logic                  prod_v_q;
  logic                  op_ready_q;
  logic                  result_valid_q;
  logic                  busy_q;
  logic                  xfer;

  assign xfer = op_valid && op_ready_q;

`ifdef MAC_SATURATE_EN
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic             sat;

  assign sum   = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
  assign sat   = sum[ACC_W];
  assign acc_d = sat ? '1 : sum[ACC_W-1:0];
  assign ovf   = ovf_q;
`else
  assign acc_d = acc_q + ACC_W'(prod_q);
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      result_q       <= '0;
      cnt_q          <= '0;
      prod_q         <= '0;
      prod_v_q       <= 1'b0;
      op_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef MAC_SATURATE_EN
      ovf_q          <= 1'b0;
`endif
    end else begin
      prod_v_q <= 1'b0;
      if (prod_v_q) begin
        acc_q <= acc_d;
`ifdef MAC_SATURATE_EN
        if (sat) ovf_q <= 1'b1;
`endif
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            op_ready_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef MAC_SATURATE_EN
            ovf_q      <= 1'b0;
`endif
          end
        end
        ACCUM: begin
          if (xfer) begin
            prod_q   <= op_a * op_b;
            prod_v_q <= 1'b1;
            cnt_q    <= cnt_q + 8'd1;
            if (cnt_q == LAST) begin
              state_q    <= DRAIN;
              op_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle captures the settled sum; then hold for the consumer.
          if (!result_valid_q) begin
            result_q       <= acc_q;
            result_valid_q <= 1'b1;
          end else if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready     = op_ready_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mac_dot_product.sv
// Bench for mac_dot_product: default, ACC_W=16 and LEN=1 instances.
// Expected sums are queued at stimulus time and popped on result handshake.
module tb_mac_dot_product;

  typedef struct {
    logic [17:0] res;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [17:0]     exp;
    logic [1:0]      gap;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s [3];
  logic [7:0]  opa [3];
  logic [7:0]  opb [3];
  logic        opv [3];
  logic        opr [3];
  logic [17:0] res [3];
  logic        rv [3];
  logic        rr [3];
  logic        busy_s [3];
  logic        ovf_s [3];
  logic [15:0] res1;
  logic [17:0] res0;
  logic [17:0] res2;

  int   checks = 0;
  int   failures = 0;
  int   cur = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign res[0] = res0;
  assign res[1] = {2'b00, res1};
  assign res[2] = res2;

  mac_dot_product u_def (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .op_a(opa[0]), .op_b(opb[0]), .op_valid(opv[0]),
    .op_ready(opr[0]), .result(res0), .result_valid(rv[0]),
    .result_ready(rr[0]), .busy(busy_s[0]), .ovf(ovf_s[0])
  );

  mac_dot_product #(.ACC_W(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .op_a(opa[1]), .op_b(opb[1]), .op_valid(opv[1]),
    .op_ready(opr[1]), .result(res1), .result_valid(rv[1]),
    .result_ready(rr[1]), .busy(busy_s[1]), .ovf(ovf_s[1])
  );

  mac_dot_product #(.LEN(1)) u_len1 (
    .clk(clk), .rst(rst), .start(start_s[2]),
    .op_a(opa[2]), .op_b(opb[2]), .op_valid(opv[2]),
    .op_ready(opr[2]), .result(res2), .result_valid(rv[2]),
    .result_ready(rr[2]), .busy(busy_s[2]), .ovf(ovf_s[2])
  );

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rv[cur] && rr[cur]) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got=%0d want=none", res[cur]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", res[cur], e.res);
        chk("ovf", ovf_s[cur], e.ovf);
      end
    end
  end

  task automatic pulse_start(int d);
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic send(int d, logic [7:0] a, logic [7:0] b, int gap);
    logic ok;
    int   n;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    opa[d] = a;
    opb[d] = b;
    opv[d] = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = opr[d];
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    opv[d] = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int n;
    rr[d] = 1'b1;
    n = 0;
    while (busy_s[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", busy_s[d], 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic push(logic [17:0] r, logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    sb.push_back(e);
  endtask

  initial begin
    vec_t vt [5];
    int   n;

    vt[0] = '{a: {8'd3, 8'd2, 8'd1}, b: {8'd6, 8'd5, 8'd4},
              exp: 18'd32, gap: 2'd0};
    vt[1] = '{a: {8'd30, 8'd20, 8'd10}, b: {8'd3, 8'd2, 8'd1},
              exp: 18'd140, gap: 2'd1};
    vt[2] = '{a: {8'd0, 8'd0, 8'd0}, b: {8'd9, 8'd8, 8'd7},
              exp: 18'd0, gap: 2'd0};
    vt[3] = '{a: {8'd50, 8'd100, 8'd200}, b: {8'd1, 8'd2, 8'd3},
              exp: 18'd850, gap: 2'd2};
    vt[4] = '{a: {8'd255, 8'd255, 8'd255}, b: {8'd255, 8'd255, 8'd255},
              exp: 18'd195075, gap: 2'd0};

    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      opa[d] = '0;
      opb[d] = '0;
      opv[d] = 1'b0;
      rr[d] = 1'b0;
    end

    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_op_ready", opr[d], 0);
      chk("rst_result", res[d], 0);
      chk("rst_valid", rv[d], 0);
      chk("rst_busy", busy_s[d], 0);
      chk("rst_ovf", ovf_s[d], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic sequence with exact latency
    cur = 0;
    rr[0] = 1'b1;
    pulse_start(0);
    chk("busy_accum", busy_s[0], 1);
    chk("op_ready_accum", opr[0], 1);
    push(18'd32, 1'b0);
    send(0, 8'd1, 8'd4, 0);
    send(0, 8'd2, 8'd5, 0);
    send(0, 8'd3, 8'd6, 0);
    chk("lat_T", rv[0], 0);
    @(posedge clk); #1;
    chk("lat_T1", rv[0], 0);
    @(posedge clk); #1;
    chk("lat_T2", rv[0], 1);
    chk("lat_T2_res", res[0], 32);
    @(posedge clk); #1;
    chk("lat_T3", rv[0], 0);
    chk("busy_after", busy_s[0], 0);
    chk("res_retained", res[0], 32);
    wait_idle(0);

    // Table-driven dot products
    for (int i = 0; i < 5; i++) begin
      pulse_start(0);
      push(vt[i].exp, 1'b0);
      for (int k = 0; k < 3; k++)
        send(0, vt[i].a[k], vt[i].b[k], int'(vt[i].gap));
      wait_idle(0);
    end

    // Stalls and back-pressure
    rr[0] = 1'b0;
    pulse_start(0);
    push(18'd195075, 1'b0);
    send(0, 8'd255, 8'd255, 0);
    send(0, 8'd255, 8'd255, 2);
    send(0, 8'd255, 8'd255, 2);
    n = 0;
    while (!rv[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", rv[0], 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rv[0], 1);
      chk("bp_hold_res", res[0], 195075);
      @(posedge clk); #1;
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_cleared", rv[0], 0);
    wait_idle(0);

    // Start during ACCUM is ignored; extra op_valid refused
    pulse_start(0);
    push(18'd3, 1'b0);
    send(0, 8'd1, 8'd1, 0);
    pulse_start(0);
    send(0, 8'd1, 8'd1, 0);
    send(0, 8'd1, 8'd1, 0);
    opv[0] = 1'b1;
    @(negedge clk);
    chk("no_4th_accept", opr[0], 0);
    @(posedge clk); #1;
    opv[0] = 1'b0;
    wait_idle(0);

    // Asynchronous reset mid-operation
    pulse_start(0);
    send(0, 8'd9, 8'd9, 0);
    send(0, 8'd9, 8'd9, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_op_ready", opr[0], 0);
    chk("arst_busy", busy_s[0], 0);
    chk("arst_valid", rv[0], 0);
    chk("arst_result", res[0], 0);
    chk("arst_ovf", ovf_s[0], 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    push(18'd12, 1'b0);
    for (int k = 0; k < 3; k++) send(0, 8'd2, 8'd2, 0);
    wait_idle(0);

    // ACC_W=16 width boundary
    cur = 1;
    rr[1] = 1'b1;
    pulse_start(1);
`ifdef MAC_SATURATE_EN
    push(18'd65535, 1'b1);
`else
    push(18'd64003, 1'b0);
`endif
    for (int k = 0; k < 3; k++) send(1, 8'd255, 8'd255, 0);
    wait_idle(1);
    pulse_start(1);
    chk("ovf_cleared_on_start", ovf_s[1], 0);
    push(18'd3, 1'b0);
    for (int k = 0; k < 3; k++) send(1, 8'd1, 8'd1, 0);
    wait_idle(1);

    // LEN=1 with back-to-back starts
    cur = 2;
    rr[2] = 1'b1;
    pulse_start(2);
    push(18'd63, 1'b0);
    send(2, 8'd7, 8'd9, 0);
    wait_idle(2);
    pulse_start(2);
    chk("len1_restart_busy", busy_s[2], 1);
    push(18'd0, 1'b0);
    send(2, 8'd0, 8'd200, 0);
    wait_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
